// File: rtl/pkg_sha3.sv
// Shared SHA-3 definitions: bus width, digest geometry and
// the shared-core arbiter state encoding.
package pkg_sha3;

   localparam int SHA3_BRAM_DW      = 64;
   localparam int SHA3_DIGEST_LINES = 4;

   typedef enum logic [2:0] {
      IDLE_S,
      CLEAR_S,
      STREAM_S,
      START_S,
      COLLECT_S
   } sha3_arb_state_t;

endpackage

// File: rtl/sha3_req_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request bit
// found searching ptr, ptr+1, ... modulo N.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   int j;

   // Walk the search order backwards so the nearest hit wins.
   always_comb begin
      j   = 0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % N;
         if (req[j[IW-1:0]]) idx = j[IW-1:0];
      end
      any = |req;
      gnt = '0;
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/sha3_req_arbiter.sv
// Round-robin job sequencer sharing one SHA-3 stream core
// between NUM_REQ requesters.
module sha3_req_arbiter
   import pkg_sha3::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int DIGEST_LINES = SHA3_DIGEST_LINES
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_REQ-1:0]                req_i,
   input  logic [NUM_REQ*SHA3_BRAM_DW-1:0]   msg_data_i,
   input  logic [NUM_REQ-1:0]                msg_valid_i,
   input  logic [NUM_REQ-1:0]                msg_last_i,
   output logic [NUM_REQ-1:0]                msg_ready_o,
   output logic [SHA3_BRAM_DW-1:0]           dig_data_o,
   output logic [NUM_REQ-1:0]                dig_valid_o,
   input  logic [NUM_REQ-1:0]                dig_ready_i,
   output logic [NUM_REQ-1:0]                grant_o,
   output logic                              busy_o,
   output logic                              core_rst_o,
   output logic                              core_start_o,
   output logic [SHA3_BRAM_DW-1:0]           core_rd_data_o,
   output logic                              core_rd_valid_o,
   input  logic                              core_rd_ready_i,
   input  logic [SHA3_BRAM_DW-1:0]           core_wr_data_i,
   input  logic                              core_wr_valid_i,
   output logic                              core_wr_ready_o
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(DIGEST_LINES + 1);
   localparam int DW = SHA3_BRAM_DW;

   sha3_arb_state_t    state;
   logic [IW-1:0]      ptr;
   logic [IW-1:0]      gidx;
   logic [NUM_REQ-1:0] grant;
   logic [CW-1:0]      cnt;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;

   logic [DW-1:0]      msg_data [NUM_REQ];
   logic               in_stream;
   logic               in_collect;
   logic               msg_fire;
   logic               dig_fire;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign msg_data[i] = msg_data_i[i*DW +: DW];
   end

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req (req_i),
      .ptr (ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign in_stream  = (state == STREAM_S);
   assign in_collect = (state == COLLECT_S);
   assign msg_fire   = in_stream & msg_valid_i[gidx] & core_rd_ready_i;
   assign dig_fire   = in_collect & core_wr_valid_i & dig_ready_i[gidx];

   // Data paths are pure forwarding; only the granted lane is opened.
   assign core_rd_data_o  = in_stream ? msg_data[gidx] : '0;
   assign core_rd_valid_o = in_stream & msg_valid_i[gidx];
   assign msg_ready_o     = in_stream ? (grant & {NUM_REQ{core_rd_ready_i}}) : '0;
   assign dig_data_o      = in_collect ? core_wr_data_i : '0;
   assign dig_valid_o     = (in_collect & core_wr_valid_i) ? grant : '0;
   assign core_wr_ready_o = in_collect & dig_ready_i[gidx];

   assign grant_o      = grant;
   assign busy_o       = (state != IDLE_S);
   assign core_rst_o   = rst_i | (state == CLEAR_S);
   assign core_start_o = (state == START_S);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE_S;
         ptr   <= '0;
         gidx  <= '0;
         grant <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE_S: begin
               if (pick_any) begin
                  grant <= pick_gnt;
                  gidx  <= pick_idx;
                  state <= CLEAR_S;
               end
            end
            CLEAR_S: state <= STREAM_S;
            STREAM_S: begin
               if (msg_fire && msg_last_i[gidx]) state <= START_S;
            end
            START_S: state <= COLLECT_S;
            COLLECT_S: begin
               if (dig_fire) begin
                  if (cnt == CW'(DIGEST_LINES - 1)) begin
                     cnt   <= '0;
                     grant <= '0;
                     state <= IDLE_S;
                     ptr   <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE_S;
               grant <= '0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
